datapath_seq: RTL
=================

Name: datapath_seq

Overview:
- Operand-fetch and write-back sequencer sitting around the datapath function unit.
- Holds the 8-entry register file and accepts one instruction at a time over a valid/ready handshake.
- Drives the function unit's FS/A/B inputs, waits for the result to settle, then writes D back and latches the V/C/N/Z status.

Parameters:
- DW, 16, datapath width (function unit A/B/D width)
- AW, 3, register address width (2**AW registers)
- SETTLE, 1, EXEC cycles allowed for function unit outputs to settle (>=1)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- INSTR  in  16  instruction word, valid with IVALID
- IVALID  in  1  producer has an instruction on INSTR
- IREADY  out  1  sequencer can accept (high only in IDLE)
- FU_FS  out  4  function-select to function unit
- FU_A  out  DW  A operand to function unit
- FU_B  out  DW  B operand to function unit
- FU_D  in  DW  result from function unit
- FU_V, FU_C, FU_N, FU_Z  in  1 each  flags from function unit
- STATUS  out  4  latched {V,C,N,Z}
- BUSY  out  1  high in any state but IDLE
- DBG_ADDR  in  AW  debug read address
- DBG_DATA  out  DW  combinational R[DBG_ADDR]

Behaviour:
- INSTR fields:
  - [15:12] FS
  - [11:9] DA
  - [8:6] AA
  - [5:3] BA
  - [2] MB: 1 = B is the constant {13'b0, BA}
  - [1] RW: 1 = write back
  - [0] reserved, ignored
- Reset (async, immediate):
  - state IDLE; all registers R0..R7 = 0; STATUS = 0
  - FU_FS = 4'b1111; FU_A = FU_B = 0
  - IREADY = 1, BUSY = 0
  - An instruction in flight is discarded with no write.
- FSM states: IDLE, FETCH, EXEC, WB.
  - IDLE: IREADY = 1. On IVALID & IREADY at a rising edge, capture INSTR into an internal IR and go to FETCH. With IVALID = 0, stay.
  - FETCH: drive FU_FS = IR.FS, FU_A = R[AA], FU_B = MB ? const : R[BA], all registered and held stable through WB. After one cycle go to EXEC.
  - EXEC: count SETTLE cycles, then go to WB.
  - WB (one cycle):
    - At its closing edge, if RW = 1 then R[DA] <= FU_D.
    - STATUS <= {FU_V,FU_C,FU_N,FU_Z} unconditionally, including when RW = 0 and when FS = 1111.
    - Go to IDLE.
- Latency:
  - Accept at edge k; write and STATUS update at edge k+2+SETTLE.
  - IREADY is high again during the following cycle.
  - Maximum throughput: one instruction per 3+SETTLE cycles.
- Back-pressure: while BUSY, IREADY = 0. The producer holds INSTR/IVALID and the sequencer ignores them.
- Hazards: no bypass is needed. A register written in WB is visible to the next instruction's FETCH because FETCH follows at least one IDLE edge.
- Same-register cases:
  - AA = BA = DA is legal; operands are read before the write.
  - DA = 0 is an ordinary writable register (no hardwired zero).
- Outside FETCH..WB: FU_FS/FU_A/FU_B keep their last driven values, so idle cycles create no operand events at the function unit.
- DBG_DATA is combinational. During a WB write it shows the old value until the edge.
- Widths: constant B is zero-extended. No arithmetic is done here; FU_D is stored as-is.

Decomposition:
- Shared package `datapath_pkg`:
  - FS opcode localparams: FS_MOVA=0000 ... FS_HOLD=1111
  - INSTR field bit positions
  - FSM state encoding: 2-bit, IDLE=00, FETCH=01, EXEC=10, WB=11
  - DW/AW defaults
- One sub-module `regfile_2r1w`:
  - 2**AW x DW
  - two combinational read ports plus a debug read port
  - one synchronous write port with enable
  - async reset to zero
- The sequencer FSM and IR stay in datapath_seq.

Test Plan:
- Reset mid-EXEC:
  - Accept instruction, assert RESET in EXEC.
  - Immediately BUSY = 0, IREADY = 1, STATUS = 0, FU_FS = 1111, all R = 0, no write.
- Constant load:
  - INSTR FS=1100 (move B), DA=3, BA=5, MB=1, RW=1; bench FU model returns D = B.
  - R3 = 16'h0005 at edge k+3 (SETTLE=1).
  - STATUS Z = 0; BUSY high for exactly 3 cycles.
- Add with overflow, register operands:
  - Preload R1 = 16'h7FFF, R2 = 16'h0001.
  - FS=0010, DA=4, AA=1, BA=2, MB=0, RW=1.
  - FU_A = 7FFF and FU_B = 0001 during EXEC.
  - R4 = 16'h8000; STATUS = {V=1,C=0,N=1,Z=0}.
- RW=0 compare:
  - FS=0101 (A - B) with R1 = R2 = 16'h1234.
  - No register changes; STATUS Z = 1, C = 1.
- Back-to-back with dependency and back-pressure:
  - Two instructions with IVALID held high; the second reads the first's DA.
  - IREADY low for 3 cycles between accepts.
  - The second's FU_A equals the first's result.
  - INSTR changes while BUSY are ignored.
- SETTLE=3 build:
  - Same constant-load stimulus.
  - Write lands at edge k+5; BUSY high for 5 cycles.

Source files
------------

// File: rtl/datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_pkg : shared opcodes, INSTR layout and sequencer states      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package datapath_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  localparam logic [3:0] FS_MOVA  = 4'b0000;
  localparam logic [3:0] FS_INCA  = 4'b0001;
  localparam logic [3:0] FS_ADD   = 4'b0010;
  localparam logic [3:0] FS_ADDC  = 4'b0011;
  localparam logic [3:0] FS_ADDNB = 4'b0100;
  localparam logic [3:0] FS_SUB   = 4'b0101;
  localparam logic [3:0] FS_DECA  = 4'b0110;
  localparam logic [3:0] FS_TRA   = 4'b0111;
  localparam logic [3:0] FS_AND   = 4'b1000;
  localparam logic [3:0] FS_OR    = 4'b1001;
  localparam logic [3:0] FS_XOR   = 4'b1010;
  localparam logic [3:0] FS_NOTA  = 4'b1011;
  localparam logic [3:0] FS_MOVB  = 4'b1100;
  localparam logic [3:0] FS_SHRB  = 4'b1101;
  localparam logic [3:0] FS_SHLB  = 4'b1110;
  localparam logic [3:0] FS_HOLD  = 4'b1111;

  localparam int FS_MSB = 15;
  localparam int FS_LSB = 12;
  localparam int DA_MSB = 11;
  localparam int DA_LSB = 9;
  localparam int AA_MSB = 8;
  localparam int AA_LSB = 6;
  localparam int BA_MSB = 5;
  localparam int BA_LSB = 3;
  localparam int MB_BIT = 2;
  localparam int RW_BIT = 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_EXEC  = 2'b10;
  localparam logic [1:0] S_WB    = 2'b11;

  typedef struct packed {
    logic [3:0] fs;
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       mb;
    logic       rw;
  } instr_t;

  // Bit 0 of INSTR is reserved, so only [15:1] is decoded.
  function automatic instr_t decode(input logic [15:1] w);
    instr_t d;
    d.fs = w[FS_MSB:FS_LSB];
    d.da = w[DA_MSB:DA_LSB];
    d.aa = w[AA_MSB:AA_LSB];
    d.ba = w[BA_MSB:BA_LSB];
    d.mb = w[MB_BIT];
    d.rw = w[RW_BIT];
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_2r1w : 2**AW x DW register file, 2 async reads + debug read,  |
// | one synchronous write. Rev 1.0                                        |
// +----------------------------------------------------------------------+
module regfile_2r1w #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_dbg_data
);

  localparam int c_DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [c_DEPTH];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/datapath_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_seq : operand-fetch / write-back sequencer around the        |
// | function unit. Rev 1.0                                                |
// +----------------------------------------------------------------------+
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int SETTLE = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [15:0]   INSTR,
  input  logic          IVALID,
  output logic          IREADY,
  output logic [3:0]    FU_FS,
  output logic [DW-1:0] FU_A,
  output logic [DW-1:0] FU_B,
  input  logic [DW-1:0] FU_D,
  input  logic          FU_V,
  input  logic          FU_C,
  input  logic          FU_N,
  input  logic          FU_Z,
  output logic [3:0]    STATUS,
  output logic          BUSY,
  input  logic [AW-1:0] DBG_ADDR,
  output logic [DW-1:0] DBG_DATA
);

  localparam int              c_CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(SETTLE - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  instr_t          r_ir;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_fs;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [3:0]      r_status;
  logic [DW-1:0]   w_rdata_a;
  logic [DW-1:0]   w_rdata_b;
  logic            w_we;
  logic            w_accept;
  logic            w_unused_rsvd;

  assign w_unused_rsvd = INSTR[0];
  assign w_accept      = IVALID && (r_state == S_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (IVALID) w_next = S_FETCH;
      S_FETCH: w_next = S_EXEC;
      S_EXEC:  if (r_cnt == c_LAST) w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    IREADY = (r_state == S_IDLE);
    BUSY   = (r_state != S_IDLE);
    w_we   = (r_state == S_WB) && r_ir.rw;
  end

  // Operand registers only move in FETCH so the function unit sees no
  // input activity while the sequencer is idle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ir     <= '0;
      r_cnt    <= '0;
      r_fs     <= FS_HOLD;
      r_a      <= '0;
      r_b      <= '0;
      r_status <= '0;
    end else begin
      if (w_accept) r_ir <= decode(INSTR[15:1]);
      r_cnt <= (r_state == S_EXEC) ? r_cnt + 1'b1 : '0;
      if (r_state == S_FETCH) begin
        r_fs <= r_ir.fs;
        r_a  <= w_rdata_a;
        r_b  <= r_ir.mb ? DW'(r_ir.ba) : w_rdata_b;
      end
      if (r_state == S_WB) r_status <= {FU_V, FU_C, FU_N, FU_Z};
    end
  end

  assign FU_FS  = r_fs;
  assign FU_A   = r_a;
  assign FU_B   = r_b;
  assign STATUS = r_status;

  regfile_2r1w #(
    .DW (DW),
    .AW (AW)
  ) u_rf (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_we       (w_we),
    .i_waddr    (r_ir.da),
    .i_wdata    (FU_D),
    .i_raddr_a  (r_ir.aa),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (r_ir.ba),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_addr (DBG_ADDR),
    .o_dbg_data (DBG_DATA)
  );

endmodule
`default_nettype wire
